// File: rtl/dds_cmd_pkg.sv
// Shared constants, state encoding and response-frame helpers
// for the UART command front end of the DDS SPI path.
package dds_cmd_pkg;

    localparam logic [7:0]  REQ_HDR     = 8'hA5;
    localparam logic [7:0]  RSP_HDR     = 8'h5A;
    localparam logic [7:0]  DIV_DEFAULT = 8'h04;
    localparam logic [15:0] GAP_TIMEOUT = 16'd50000;
    localparam logic [23:0] SPI_TIMEOUT = 24'd1000000;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] CMD_DIV  = 8'h03;
    localparam logic [7:0] CMD_INIT = 8'h04;

    localparam logic [7:0] NAK_MARK = 8'hEE;
    localparam logic [7:0] NAK_CHK  = 8'h01;
    localparam logic [7:0] NAK_CMD  = 8'h02;
    localparam logic [7:0] NAK_TMO  = 8'h03;

    typedef enum logic [3:0] {
        HUNT,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        CHECK,
        SPI_START,
        SPI_WAIT,
        CFG,
        RESP
    } state_e;

    // Byte 0 goes out first.
    typedef logic [4:0][7:0] frame_t;

    function automatic frame_t ok_frame(
        input logic [7:0] c,
        input logic [7:0] a,
        input logic [7:0] d
    );
        return {c ^ a ^ d, d, a, c, RSP_HDR};
    endfunction

    // A NAK has the success layout with EE in the command slot.
    function automatic frame_t nak_frame(
        input logic [7:0] c,
        input logic [7:0] code
    );
        return ok_frame(NAK_MARK, c, code);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_serializer.sv
// Five-byte response shifter: load a frame, then present one byte
// at a time on a valid/ready handshake.
module cmd_rsp_serializer
    import dds_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  frame_t     frame,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       done
);

    frame_t     buf_q;
    logic [2:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            buf_q    <= frame;
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (idx == 3'd4) begin
                tx_valid <= 1'b0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    assign tx_data = tx_valid ? buf_q[idx] : 8'h00;
    assign done    = tx_valid && tx_ready && (idx == 3'd4);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 5-byte host frames, drives the SPI master, and returns a
// 5-byte success or NAK response through the UART transmitter.
module uart_cmd_decoder
    import dds_cmd_pkg::*;
#(
    parameter logic [23:0] GAP_LIMIT = 24'(GAP_TIMEOUT),
    parameter logic [23:0] SPI_LIMIT = SPI_TIMEOUT
) (
    input  logic       sclk,
    input  logic       srstn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       wr_start,
    output logic       rd_start,
    output logic [7:0] start_addr,
    output logic [7:0] rx_rd_data,
    output logic [7:0] state_init,
    output logic [7:0] sclk_divider,
    input  logic       wr_finish,
    input  logic       rd_finish,
    input  logic [7:0] tx_wr_data,
    output logic       busy
);

    state_e     state, state_nx;
    logic [7:0] cmd, addr, data, chk;
    logic [23:0] cnt;
    logic       in_get, take, gap_to, spi_fin, spi_to;
    logic       load, rsp_done;
    frame_t     frame;

    assign in_get  = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    assign take    = in_get && rx_valid;
    assign gap_to  = in_get && !rx_valid
                     && (cnt == GAP_LIMIT - 24'd1);
    assign spi_fin = (cmd == CMD_RD) ? rd_finish : wr_finish;
    assign spi_to  = !spi_fin && (cnt == SPI_LIMIT - 24'd1);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        frame    = '0;
        unique case (state)
            HUNT: begin
                if (rx_valid && rx_data == REQ_HDR) state_nx = GET_CMD;
            end
            GET_CMD: begin
                if (take)        state_nx = GET_ADDR;
                else if (gap_to) state_nx = HUNT;
            end
            GET_ADDR: begin
                if (take)        state_nx = GET_DATA;
                else if (gap_to) state_nx = HUNT;
            end
            GET_DATA: begin
                if (take)        state_nx = GET_CHK;
                else if (gap_to) state_nx = HUNT;
            end
            GET_CHK: begin
                if (take)        state_nx = CHECK;
                else if (gap_to) state_nx = HUNT;
            end
            CHECK: begin
                if (chk != (cmd ^ addr ^ data)) begin
                    load     = 1'b1;
                    frame    = nak_frame(cmd, NAK_CHK);
                    state_nx = RESP;
                end else if (cmd == CMD_WR || cmd == CMD_RD) begin
                    state_nx = SPI_START;
                end else if (cmd == CMD_DIV || cmd == CMD_INIT) begin
                    state_nx = CFG;
                end else begin
                    load     = 1'b1;
                    frame    = nak_frame(cmd, NAK_CMD);
                    state_nx = RESP;
                end
            end
            SPI_START: state_nx = SPI_WAIT;
            SPI_WAIT: begin
                if (spi_fin) begin
                    load     = 1'b1;
                    frame    = ok_frame(cmd, addr,
                        (cmd == CMD_RD) ? tx_wr_data : data);
                    state_nx = RESP;
                end else if (spi_to) begin
                    load     = 1'b1;
                    frame    = nak_frame(cmd, NAK_TMO);
                    state_nx = RESP;
                end
            end
            CFG: begin
                load     = 1'b1;
                frame    = ok_frame(cmd, addr, data);
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_done) state_nx = HUNT;
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            // Shared gap/SPI counter: restarts on entry and on each byte.
            if (state_nx != state || take) begin
                cnt <= '0;
            end else if (in_get || state == SPI_WAIT) begin
                cnt <= cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            cmd  <= '0;
            addr <= '0;
            data <= '0;
            chk  <= '0;
        end else if (take) begin
            unique case (state)
                GET_CMD:  cmd  <= rx_data;
                GET_ADDR: addr <= rx_data;
                GET_DATA: data <= rx_data;
                default:  chk  <= rx_data;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            start_addr   <= '0;
            rx_rd_data   <= '0;
            state_init   <= '0;
            sclk_divider <= DIV_DEFAULT;
        end else begin
            if (state == CHECK && state_nx == SPI_START) begin
                start_addr <= addr;
                if (cmd == CMD_WR) rx_rd_data <= data;
            end
            if (state == CFG) begin
                if (cmd == CMD_DIV) sclk_divider <= data;
                else                state_init   <= data;
            end
        end
    end

    assign wr_start = (state == SPI_START) && (cmd == CMD_WR);
    assign rd_start = (state == SPI_START) && (cmd == CMD_RD);
    assign busy     = (state != HUNT);

    cmd_rsp_serializer u_ser (
        .clk      (sclk),
        .rst_n    (srstn),
        .load     (load),
        .frame    (frame),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (rsp_done)
    );

endmodule
